// File: rtl/ahb_apb_bridge_ctrl_p_if.sv
// AHB-Lite / APB3 signal bundle for ahb_apb_bridge_ctrl_p.
// slave = bridge view (AHB slave, APB master); master = interconnect and peripheral view.
interface ahb_apb_bridge_ctrl_p_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 4
);
    logic                   HSEL;
    logic [1:0]             HTRANS;
    logic [ADDR_W-1:0]      HADDR;
    logic                   HWRITE;
    logic [DATA_W-1:0]      HWDATA;
    logic                   HREADY;
    logic                   HREADYOUT;
    logic                   HRESP;
    logic [DATA_W-1:0]      HRDATA;
    logic [NSLV-1:0]        PSEL;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [ADDR_W-1:0]      PADDR;
    logic [DATA_W-1:0]      PWDATA;
    logic [NSLV*DATA_W-1:0] PRDATA;
    logic [NSLV-1:0]        PREADY;
    logic [NSLV-1:0]        PSLVERR;

    modport slave (
        input  HSEL, HTRANS, HADDR, HWRITE, HWDATA, HREADY, PRDATA, PREADY, PSLVERR,
        output HREADYOUT, HRESP, HRDATA, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport master (
        output HSEL, HTRANS, HADDR, HWRITE, HWDATA, HREADY, PRDATA, PREADY, PSLVERR,
        input  HREADYOUT, HRESP, HRDATA, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/ahb_apb_bridge_ctrl_p.sv
// AHB-Lite slave to APB3 master bridge with one-hot PSEL decode and two-cycle AHB ERROR.
// Define APB_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT_CYC cycles.
module ahb_apb_bridge_ctrl_p #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NSLV        = 4,
    parameter int SEL_LSB     = 12,
    parameter int TIMEOUT_CYC = 16
) (
    input logic                    HCLK,
    input logic                    HRESETn,
    ahb_apb_bridge_ctrl_p_if.slave bus
);
    localparam int IDXW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam logic [IDXW:0] SLV_CNT = (IDXW+1)'(NSLV);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } state_t;

    state_t            r_state;
    logic [IDXW-1:0]   r_idx;
    logic              r_hreadyout;
    logic              r_hresp;
    logic [DATA_W-1:0] r_hrdata;
    logic [NSLV-1:0]   r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;

    logic              w_valid;
    logic              w_decErr;
    logic [IDXW-1:0]   w_hidx;
    logic              w_pready;
    logic              w_pslverr;
    logic [DATA_W-1:0] w_prdata;
    logic              w_unused;

`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] r_tmoCnt;
    assign w_unused = bus.HTRANS[0];
`else
    assign w_unused = bus.HTRANS[0] ^ (TIMEOUT_CYC == 0);
`endif

    function automatic logic [NSLV-1:0] oneHot(input logic [IDXW-1:0] idx);
        logic [NSLV-1:0] v;
        v = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (idx == IDXW'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    assign w_valid  = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    assign w_hidx   = bus.HADDR[SEL_LSB +: IDXW];
    assign w_decErr = ({1'b0, w_hidx} >= SLV_CNT);

    // Only the slave addressed by the current transfer is listened to.
    always_comb begin
        w_pready  = 1'b0;
        w_pslverr = 1'b0;
        w_prdata  = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_pready  = bus.PREADY[i];
                w_pslverr = bus.PSLVERR[i];
                w_prdata  = bus.PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hrdata    <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
`ifdef APB_TIMEOUT_EN
            r_tmoCnt    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_hreadyout <= 1'b0;
                        if (w_decErr) begin
                            r_hresp <= 1'b1;
                            r_state <= S_ERR1;
                        end else begin
                            r_idx    <= w_hidx;
                            r_paddr  <= bus.HADDR;
                            r_pwrite <= bus.HWRITE;
                            if (bus.HWRITE) begin
                                r_state <= S_LATCH;
                            end else begin
                                r_psel  <= oneHot(w_hidx);
                                r_state <= S_SETUP;
                            end
                        end
                    end
                end
                S_LATCH: begin
                    r_pwdata <= bus.HWDATA;
                    r_psel   <= oneHot(r_idx);
                    r_state  <= S_SETUP;
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    r_tmoCnt  <= '0;
`endif
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_pready) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        if (w_pslverr) begin
                            r_hresp <= 1'b1;
                            r_state <= S_ERR1;
                        end else begin
                            r_hreadyout <= 1'b1;
                            if (!r_pwrite) r_hrdata <= w_prdata;
                            r_state <= S_IDLE;
                        end
                    end
`ifdef APB_TIMEOUT_EN
                    // A stalled slave is abandoned after TIMEOUT_CYC wait cycles.
                    else if (r_tmoCnt == TMO_LAST) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_hresp   <= 1'b1;
                        r_state   <= S_ERR1;
                    end else begin
                        r_tmoCnt <= r_tmoCnt + 1'b1;
                    end
`endif
                end
                S_ERR1: begin
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                    r_state     <= S_ERR2;
                end
                S_ERR2: begin
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                    r_psel      <= '0;
                    r_penable   <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.HREADYOUT = r_hreadyout;
    assign bus.HRESP     = r_hresp;
    assign bus.HRDATA    = r_hrdata;
    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
endmodule
